alu_acc_stage: RTL and testbench

//   Accumulator stage wrapped around one four_bit_alu slice. Accepts commands over a

---
 rtl/alu_pkg.sv | 19 +
 rtl/four_bit_alu.sv | 25 ++
 rtl/alu_acc_stage.sv | 101 ++++++++++
 tb/tb_alu_acc_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and helpers for the accumulator stage.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Add and sub use the carry chain; xor/xnor do not.
  function automatic logic op_is_arith(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/four_bit_alu.sv
// Combinational 4-bit ALU slice.
// M inverts B; Cen enables the carry chain (arithmetic) with M as carry-in.
// With Cen=0 the slice produces A^B (M=0) or A xnor B (M=1) and Cout=0.
module four_bit_alu (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  input  logic       Cen,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] bx;

  // Operand conditioning and sum / logic result.
  always_comb begin
    bx   = M ? ~B : B;
    S    = A ^ bx;
    Cout = 1'b0;
    if (Cen) begin
      {Cout, S} = {1'b0, A} + {1'b0, bx} + {4'b0000, M};
    end
  end

endmodule

// File: rtl/alu_acc_stage.sv
// Accumulator stage around one four_bit_alu slice, with a one-deep result
// register presented over a valid/ready handshake.
module alu_acc_stage
  import alu_pkg::*;
#(
  parameter logic [3:0] ACC_INIT = 4'h0,
  parameter int         SEQ_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_operand,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_acc,
  output logic             res_c,
  output logic             res_z,
  output logic             res_v,
  output logic [SEQ_W-1:0] res_seq
);

  stage_state_e     state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic [SEQ_W-1:0] seq_q, seq_d;

  logic [3:0]       alu_s;
  logic             alu_cout;
  logic             accept;
  logic             arith;

  four_bit_alu u_alu (
    .A    (acc_q),
    .B    (cmd_operand),
    .M    (cmd_op[0]),
    .Cen  (~cmd_op[1]),
    .S    (alu_s),
    .Cout (alu_cout)
  );

  assign res_valid = (state_q == ST_FULL);
  assign cmd_ready = rst_n & (~res_valid | res_ready);
  assign accept    = cmd_valid & cmd_ready;
  assign arith     = op_is_arith(cmd_op) & ~cmd_load;

  // Handshake FSM: a result is held until consumed, or replaced by a new accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (res_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Next accumulator, flags and sequence number for the command being offered.
  always_comb begin
    acc_d = cmd_load ? cmd_operand : alu_s;
    z_d   = (acc_d == 4'h0);
    c_d   = arith & alu_cout;
    v_d   = 1'b0;
    if (arith) begin
      if (cmd_op == OP_SUB) v_d = (acc_q[3] != cmd_operand[3]) & (alu_s[3] != acc_q[3]);
      else                  v_d = (acc_q[3] == cmd_operand[3]) & (alu_s[3] != acc_q[3]);
    end
    seq_d = seq_q + SEQ_W'(1);
  end

  // State and result registers; results update only on an accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      acc_q   <= ACC_INIT;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= acc_d;
        c_q   <= c_d;
        z_q   <= z_d;
        v_q   <= v_d;
        seq_q <= seq_d;
      end
    end
  end

  assign res_acc = acc_q;
  assign res_c   = c_q;
  assign res_z   = z_q;
  assign res_v   = v_q;
  assign res_seq = seq_q;

endmodule

// File: tb/tb_alu_acc_stage.sv
// Bench for alu_acc_stage: directed command sequence, an arithmetic reference
// model of the stage, and a per-cycle compare against that model.
module tb_alu_acc_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [1:0] cmd_op;
  logic [3:0] cmd_operand;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_acc;
  logic       res_c;
  logic       res_z;
  logic       res_v;
  logic [3:0] res_seq;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_valid = 0;
  int m_acc   = 0;
  int m_c     = 0;
  int m_z     = 0;
  int m_v     = 0;
  int m_seq   = 0;

  alu_acc_stage #(.ACC_INIT(4'h0), .SEQ_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_acc     (res_acc),
    .res_c       (res_c),
    .res_z       (res_z),
    .res_v       (res_v),
    .res_seq     (res_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int to_signed4(input int x);
    return (x > 7) ? x - 16 : x;
  endfunction

  // Model: evaluates each accepted command with plain integer arithmetic.
  always @(posedge clk) begin : model
    int ready, a, b, r, sr, c, v;
    if (rst_n !== 1'b1) begin
      m_valid = 0; m_acc = 0; m_c = 0; m_z = 0; m_v = 0; m_seq = 0;
    end else begin
      ready = (m_valid == 0 || res_ready == 1'b1) ? 1 : 0;
      if (ready == 1 && cmd_valid == 1'b1) begin
        a = m_acc;
        b = int'(cmd_operand);
        c = 0; v = 0;
        if (cmd_load) r = b;
        else begin
          case (cmd_op)
            2'b00: begin
              r  = a + b;
              c  = (r > 15) ? 1 : 0;
              sr = to_signed4(a) + to_signed4(b);
              v  = (sr > 7 || sr < -8) ? 1 : 0;
            end
            2'b01: begin
              r  = a - b;
              c  = (a >= b) ? 1 : 0;
              sr = to_signed4(a) - to_signed4(b);
              v  = (sr > 7 || sr < -8) ? 1 : 0;
            end
            2'b10:   r = a ^ b;
            default: r = 15 - (a ^ b);
          endcase
        end
        r = ((r % 16) + 16) % 16;
        m_acc = r; m_c = c; m_v = v; m_z = (r == 0) ? 1 : 0;
        m_seq = (m_seq + 1) % 16;
        m_valid = 1;
      end else if (res_ready == 1'b1) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    int exp_ready;
    exp_ready = (rst_n == 1'b1 && (m_valid == 0 || res_ready == 1'b1)) ? 1 : 0;
    chk("m_cmd_ready", int'(cmd_ready), exp_ready);
    chk("m_res_valid", int'(res_valid), m_valid);
    chk("m_res_acc",   int'(res_acc),   m_acc);
    chk("m_res_c",     int'(res_c),     m_c);
    chk("m_res_z",     int'(res_z),     m_z);
    chk("m_res_v",     int'(res_v),     m_v);
    chk("m_res_seq",   int'(res_seq),   m_seq);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic load, input logic [1:0] op, input logic [3:0] opnd);
    cmd_valid   = 1'b1;
    cmd_load    = load;
    cmd_op      = op;
    cmd_operand = opnd;
    cyc();
    cmd_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00;
    cmd_operand = 4'h0; res_ready = 1'b1;

    // 1. Reset
    cyc(); cyc();
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_acc",   int'(res_acc),   0);
    chk("rst_seq",   int'(res_seq),   0);
    chk("rst_ready", int'(cmd_ready), 0);
    rst_n = 1'b1; #1;
    chk("rel_ready", int'(cmd_ready), 1);

    // 2. Load 7, add 1
    send(1'b1, 2'b00, 4'h7);
    send(1'b0, 2'b00, 4'h1);
    chk("add_acc", int'(res_acc), 8);
    chk("add_c",   int'(res_c),   0);
    chk("add_v",   int'(res_v),   1);
    chk("add_z",   int'(res_z),   0);
    chk("add_seq", int'(res_seq), 2);
    chk("add_vld", int'(res_valid), 1);

    // 3. Load 3, sub 3, sub 1
    send(1'b1, 2'b00, 4'h3);
    send(1'b0, 2'b01, 4'h3);
    chk("sub0_acc", int'(res_acc), 0);
    chk("sub0_z",   int'(res_z),   1);
    chk("sub0_c",   int'(res_c),   1);
    chk("sub0_v",   int'(res_v),   0);
    send(1'b0, 2'b01, 4'h1);
    chk("subF_acc", int'(res_acc), 15);
    chk("subF_c",   int'(res_c),   0);

    // 4. Logic ops from acc=A
    send(1'b1, 2'b00, 4'hA);
    send(1'b0, 2'b10, 4'hF);
    chk("xor_acc", int'(res_acc), 5);
    chk("xor_c",   int'(res_c),   0);
    chk("xor_v",   int'(res_v),   0);
    send(1'b0, 2'b11, 4'h5);
    chk("xnor_acc", int'(res_acc), 15);
    chk("xnor_seq", int'(res_seq), 8);

    // 5. Backpressure with a pending command, then consume+accept on one edge
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b00; cmd_operand = 4'h1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_ready", int'(cmd_ready), 0);
      chk("stall_acc",   int'(res_acc),   15);
      chk("stall_seq",   int'(res_seq),   8);
      chk("stall_vld",   int'(res_valid), 1);
    end
    res_ready = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    chk("bb_acc", int'(res_acc),   0);
    chk("bb_c",   int'(res_c),     1);
    chk("bb_z",   int'(res_z),     1);
    chk("bb_seq", int'(res_seq),   9);
    chk("bb_vld", int'(res_valid), 1);

    // 6. Reset while a result is stalled
    res_ready = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("mrst_vld",   int'(res_valid), 0);
    chk("mrst_acc",   int'(res_acc),   0);
    chk("mrst_seq",   int'(res_seq),   0);
    chk("mrst_ready", int'(cmd_ready), 0);
    rst_n = 1'b1; res_ready = 1'b1;

    // 16 back-to-back adds: sequence and accumulator both wrap to 0
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b00; cmd_operand = 4'h1;
    for (int i = 0; i < 16; i++) cyc();
    cmd_valid = 1'b0;
    chk("wrap_seq", int'(res_seq),   0);
    chk("wrap_acc", int'(res_acc),   0);
    chk("wrap_c",   int'(res_c),     1);
    chk("wrap_vld", int'(res_valid), 1);
    cyc();
    chk("drain_vld", int'(res_valid), 0);
    chk("drain_acc", int'(res_acc),   0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
